// File: rtl/mips_pkg.sv
// Shared MIPS control constants: opcode/funct values, control-field encodings,
// the ID/EX control word layout and the opcode decoder.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_JAL   = 6'd3;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_ADDIU = 6'd9;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIVU  = 6'h1B;

  typedef enum logic [1:0] {REGDST_RT = 2'b00, REGDST_RD = 2'b01, REGDST_RA = 2'b10} regdst_e;
  typedef enum logic [1:0] {WB_ALU = 2'b00, WB_MEM = 2'b01, WB_PC4 = 2'b10} memtoreg_e;
  typedef enum logic [1:0] {ALU_ADD = 2'b00, ALU_SUB = 2'b01, ALU_FUNCT = 2'b10} aluop_e;

  typedef enum logic {IDLE = 1'b0, MBUSY = 1'b1} mul_state_e;

  typedef struct packed {
    regdst_e   regDst;
    memtoreg_e memToReg;
    aluop_e    aluOp;
    logic      aluSrc;
    logic      regWrite;
    logic      memRead;
    logic      memWrite;
    logic      branch;
    logic      jump;
  } ctrl_t;

  localparam int    CTRL_W   = $bits(ctrl_t);
  localparam ctrl_t CTRL_NOP = '0;

  function automatic ctrl_t decodeOp(input logic [5:0] op);
    ctrl_t c;
    c = CTRL_NOP;
    case (op)
      OP_RTYPE: begin
        c.regDst   = REGDST_RD;
        c.regWrite = 1'b1;
        c.aluOp    = ALU_FUNCT;
      end
      OP_LW: begin
        c.aluSrc   = 1'b1;
        c.memToReg = WB_MEM;
        c.regWrite = 1'b1;
        c.memRead  = 1'b1;
        c.aluOp    = ALU_ADD;
      end
      OP_SW: begin
        c.aluSrc   = 1'b1;
        c.memWrite = 1'b1;
      end
      OP_BEQ: begin
        c.branch = 1'b1;
        c.aluOp  = ALU_SUB;
      end
      OP_J: begin
        c.branch = 1'b1;
        c.jump   = 1'b1;
      end
      OP_JAL: begin
        c.regDst   = REGDST_RA;
        c.memToReg = WB_PC4;
        c.regWrite = 1'b1;
        c.branch   = 1'b1;
        c.jump     = 1'b1;
      end
      OP_ADDIU: begin
        c.aluSrc   = 1'b1;
        c.regWrite = 1'b1;
      end
      default: c = CTRL_NOP;
    endcase
    return c;
  endfunction

  function automatic logic isLegalOp(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_JAL, OP_ADDIU: return 1'b1;
      default:                                                return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mul_seq_tracker.sv
// Multiplier/divider occupancy tracker: counts MUL_LAT busy cycles after a start.
module mul_seq_tracker
  import mips_pkg::*;
#(
  parameter int MUL_LAT = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic busy,
  output logic done
);

  localparam int             CW   = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  localparam logic [CW-1:0]  LOAD = CW'(MUL_LAT - 1);

  mul_state_e    r_state;
  mul_state_e    w_nextState;
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_nextCount;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_count <= '0;
    end else begin
      r_state <= w_nextState;
      r_count <= w_nextCount;
    end
  end

  // The count reaching zero ends the operation, so it never wraps.
  always_comb begin
    w_nextState = r_state;
    w_nextCount = r_count;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_nextState = MBUSY;
          w_nextCount = LOAD;
        end
      end
      MBUSY: begin
        if (r_count == '0) begin
          w_nextState = IDLE;
        end else begin
          w_nextCount = r_count - CW'(1);
        end
      end
      default: begin
        w_nextState = IDLE;
        w_nextCount = '0;
      end
    endcase
  end

  assign busy = (r_state == MBUSY);
  assign done = busy && (r_count == '0);

endmodule

// File: rtl/mips_ctrl_seq.sv
// ID-stage control unit: registered decode, load-use and multiplier hazard
// stalls, branch flush, and multiplier start sequencing.
module mips_ctrl_seq
  import mips_pkg::*;
#(
  parameter int MUL_LAT = 32,
  parameter int HAZ_EN  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr_in,
  input  logic        valid_in,
  input  logic        idex_memread,
  input  logic [4:0]  idex_rt,
  input  logic        branch_taken,
  output logic [1:0]  RegDst,
  output logic [1:0]  MemtoReg,
  output logic [1:0]  ALUOp,
  output logic        ALUSrc,
  output logic        RegWrite,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        Branch,
  output logic        Jump,
  output logic        Mulrst,
  output logic        stall,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        mul_busy,
  output logic        illegal
);

  logic [5:0]        w_opcode;
  logic [5:0]        w_funct;
  logic [4:0]        w_rs;
  logic [4:0]        w_rt;
  logic              w_isRtype;
  logic              w_isMulOp;
  logic              w_usesMulUnit;
  logic              w_present;
  logic              w_loadUse;
  logic              w_mulHazard;
  logic              w_stall;
  logic              w_bubble;
  logic              w_mulStart;
  logic              w_mulBusy;
  logic              w_mulDone;
  ctrl_t             w_decoded;
  ctrl_t             w_ctrlOut;
  logic [CTRL_W-1:0] r_ctrlWord;
  logic              r_mulrst;
  logic              r_illegal;

  assign w_opcode      = instr_in[31:26];
  assign w_funct       = instr_in[5:0];
  assign w_rs          = instr_in[25:21];
  assign w_rt          = instr_in[20:16];
  assign w_isRtype     = (w_opcode == OP_RTYPE);
  assign w_isMulOp     = w_isRtype && ((w_funct == FN_MULTU) || (w_funct == FN_DIVU));
  assign w_usesMulUnit = w_isMulOp || (w_isRtype && ((w_funct == FN_MFHI) || (w_funct == FN_MFLO)));
  assign w_present     = valid_in && (instr_in != '0);

  assign w_loadUse = (HAZ_EN != 0) && valid_in && idex_memread && (idex_rt != '0) &&
                     ((idex_rt == w_rs) || (idex_rt == w_rt));

  // The done cycle is the last busy cycle, so it still blocks the unit.
  assign w_mulHazard = (w_mulBusy || w_mulDone) && valid_in && w_usesMulUnit;

  // A taken branch flushes ID, which removes any reason to hold it.
  assign w_stall    = (w_loadUse || w_mulHazard) && !branch_taken;
  assign w_bubble   = !w_present || w_stall || branch_taken;
  assign w_mulStart = !w_bubble && w_isMulOp && !w_mulBusy;
  assign w_decoded  = decodeOp(w_opcode);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ctrlWord <= '0;
      r_mulrst   <= 1'b0;
      r_illegal  <= 1'b0;
    end else begin
      r_ctrlWord <= w_bubble ? CTRL_NOP : w_decoded;
      r_mulrst   <= w_mulStart;
      r_illegal  <= !w_bubble && !isLegalOp(w_opcode);
    end
  end

  mul_seq_tracker #(
    .MUL_LAT(MUL_LAT)
  ) u_mulTracker (
    .clk  (clk),
    .rst  (rst),
    .start(w_mulStart),
    .busy (w_mulBusy),
    .done (w_mulDone)
  );

  assign w_ctrlOut  = ctrl_t'(r_ctrlWord);
  assign RegDst     = w_ctrlOut.regDst;
  assign MemtoReg   = w_ctrlOut.memToReg;
  assign ALUOp      = w_ctrlOut.aluOp;
  assign ALUSrc     = w_ctrlOut.aluSrc;
  assign RegWrite   = w_ctrlOut.regWrite;
  assign MemRead    = w_ctrlOut.memRead;
  assign MemWrite   = w_ctrlOut.memWrite;
  assign Branch     = w_ctrlOut.branch;
  assign Jump       = w_ctrlOut.jump;
  assign Mulrst     = r_mulrst;
  assign illegal    = r_illegal;
  assign mul_busy   = w_mulBusy;
  assign stall      = w_stall;
  assign pc_write   = !w_stall;
  assign ifid_write = !w_stall;

endmodule

// File: tb/tb_mips_ctrl_seq.sv
// Scoreboard bench for mips_ctrl_seq: the driver queues hand-computed
// expectations per cycle, the monitor pops and checks them.
module tb_mips_ctrl_seq;

  logic        clk;
  logic        rst;
  logic [31:0] instrIn;
  logic        validIn;
  logic        idexMemread;
  logic [4:0]  idexRt;
  logic        branchTaken;
  logic [1:0]  regDst, memtoReg, aluOp;
  logic        aluSrc, regWrite, memRead, memWrite, branch, jump;
  logic        mulrst, stall, pcWrite, ifidWrite, mulBusy, illegal;

  int checks = 0;
  int errors = 0;
  int stepId = 0;

  // {RegDst, MemtoReg, ALUOp, ALUSrc, RegWrite, MemRead, MemWrite, Branch, Jump}
  localparam logic [11:0] C_NOP   = 12'b00_00_00_000000;
  localparam logic [11:0] C_R     = 12'b01_00_10_010000;
  localparam logic [11:0] C_LW    = 12'b00_01_00_111000;
  localparam logic [11:0] C_SW    = 12'b00_00_00_100100;
  localparam logic [11:0] C_BEQ   = 12'b00_00_01_000010;
  localparam logic [11:0] C_J     = 12'b00_00_00_000011;
  localparam logic [11:0] C_JAL   = 12'b10_10_00_010011;
  localparam logic [11:0] C_ADDIU = 12'b00_00_00_110000;

  localparam logic [31:0] I_LW    = 32'h8C020004;
  localparam logic [31:0] I_ADDU  = 32'h00432021;
  localparam logic [31:0] I_SW    = 32'hAC030008;
  localparam logic [31:0] I_BEQ   = 32'h10400004;
  localparam logic [31:0] I_J     = 32'h08000010;
  localparam logic [31:0] I_JAL   = 32'h0C000010;
  localparam logic [31:0] I_ADDIU = 32'h24050001;
  localparam logic [31:0] I_BAD   = 32'hFC000000;
  localparam logic [31:0] I_MULTU = 32'h00A60019;
  localparam logic [31:0] I_DIVU  = 32'h00A6001B;
  localparam logic [31:0] I_MFLO  = 32'h00004012;

  typedef struct {
    int          id;
    logic        stall;
    logic [11:0] ctrl;
    logic        ill;
    logic        mrst;
    logic        busy;
  } exp_t;

  exp_t expQ[$];

  mips_ctrl_seq #(
    .MUL_LAT(4),
    .HAZ_EN (1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .instr_in    (instrIn),
    .valid_in    (validIn),
    .idex_memread(idexMemread),
    .idex_rt     (idexRt),
    .branch_taken(branchTaken),
    .RegDst      (regDst),
    .MemtoReg    (memtoReg),
    .ALUOp       (aluOp),
    .ALUSrc      (aluSrc),
    .RegWrite    (regWrite),
    .MemRead     (memRead),
    .MemWrite    (memWrite),
    .Branch      (branch),
    .Jump        (jump),
    .Mulrst      (mulrst),
    .stall       (stall),
    .pc_write    (pcWrite),
    .ifid_write  (ifidWrite),
    .mul_busy    (mulBusy),
    .illegal     (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s step %0d: got %0h expected %0h", name, id, act, exp);
    end
  endtask

  function automatic logic [11:0] ctrlWord();
    return {regDst, memtoReg, aluOp, aluSrc, regWrite, memRead, memWrite, branch, jump};
  endfunction

  function automatic logic anyX();
    return $isunknown({ctrlWord(), mulrst, stall, pcWrite, ifidWrite, mulBusy, illegal});
  endfunction

  // Inputs change on the falling edge; the matching expectation is queued at once.
  task automatic applyStimulus(input logic [31:0] instr, input logic v, input logic mr,
                               input logic [4:0] rt, input logic br, input logic eStall,
                               input logic [11:0] eCtrl, input logic eIll,
                               input logic eMrst, input logic eBusy);
    exp_t e;
    @(negedge clk);
    instrIn     = instr;
    validIn     = v;
    idexMemread = mr;
    idexRt      = rt;
    branchTaken = br;
    stepId++;
    e.id    = stepId;
    e.stall = eStall;
    e.ctrl  = eCtrl;
    e.ill   = eIll;
    e.mrst  = eMrst;
    e.busy  = eBusy;
    expQ.push_back(e);
  endtask

  // Combinational hazard outputs are checked mid-cycle, registered ones just after the edge.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (expQ.size() != 0) begin
        e = expQ.pop_front();
        checkOutput("stall", e.id, {31'b0, stall}, {31'b0, e.stall});
        checkOutput("pc_write", e.id, {31'b0, pcWrite}, {31'b0, !e.stall});
        checkOutput("ifid_write", e.id, {31'b0, ifidWrite}, {31'b0, !e.stall});
        @(posedge clk);
        #1;
        checkOutput("ctrl", e.id, {20'b0, ctrlWord()}, {20'b0, e.ctrl});
        checkOutput("illegal", e.id, {31'b0, illegal}, {31'b0, e.ill});
        checkOutput("Mulrst", e.id, {31'b0, mulrst}, {31'b0, e.mrst});
        checkOutput("mul_busy", e.id, {31'b0, mulBusy}, {31'b0, e.busy});
        checkOutput("no_x", e.id, {31'b0, anyX()}, 32'd0);
      end
    end
  end

  initial begin : watchdog
    #20000;
    $display("[TB] FAIL watchdog: simulation time exceeded, got no finish expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkAllZero(input string name);
    checkOutput({name, "_ctrl"}, 0, {20'b0, ctrlWord()}, 32'd0);
    checkOutput({name, "_Mulrst"}, 0, {31'b0, mulrst}, 32'd0);
    checkOutput({name, "_mul_busy"}, 0, {31'b0, mulBusy}, 32'd0);
    checkOutput({name, "_illegal"}, 0, {31'b0, illegal}, 32'd0);
    checkOutput({name, "_no_x"}, 0, {31'b0, anyX()}, 32'd0);
  endtask

  initial begin : driver
    rst         = 1'b0;
    instrIn     = '0;
    validIn     = 1'b0;
    idexMemread = 1'b0;
    idexRt      = '0;
    branchTaken = 1'b0;
    #12;
    checkAllZero("reset");
    @(negedge clk);
    rst = 1'b1;

    //            instr    v  mr rt  br stall ctrl    ill mrst busy
    applyStimulus(I_ADDU,  1, 0, 0,  0, 0,    C_R,     0, 0, 0);
    applyStimulus(I_LW,    1, 0, 0,  0, 0,    C_LW,    0, 0, 0);
    applyStimulus(I_ADDU,  1, 1, 2,  0, 1,    C_NOP,   0, 0, 0);
    applyStimulus(I_ADDU,  1, 0, 0,  0, 0,    C_R,     0, 0, 0);
    applyStimulus(I_SW,    1, 1, 0,  0, 0,    C_SW,    0, 0, 0);
    applyStimulus(I_ADDU,  1, 1, 3,  0, 1,    C_NOP,   0, 0, 0);
    applyStimulus(I_ADDU,  1, 0, 0,  0, 0,    C_R,     0, 0, 0);
    applyStimulus(I_BEQ,   1, 1, 2,  1, 0,    C_NOP,   0, 0, 0);
    applyStimulus(I_BEQ,   1, 0, 0,  0, 0,    C_BEQ,   0, 0, 0);
    applyStimulus(I_J,     1, 0, 0,  0, 0,    C_J,     0, 0, 0);
    applyStimulus(I_JAL,   1, 0, 0,  0, 0,    C_JAL,   0, 0, 0);
    applyStimulus(I_ADDIU, 1, 0, 0,  0, 0,    C_ADDIU, 0, 0, 0);
    applyStimulus(I_BAD,   1, 0, 0,  0, 0,    C_NOP,   1, 0, 0);
    applyStimulus(32'h0,   1, 0, 0,  0, 0,    C_NOP,   0, 0, 0);
    applyStimulus(I_ADDIU, 0, 0, 0,  0, 0,    C_NOP,   0, 0, 0);

    applyStimulus(I_MULTU, 1, 0, 0,  0, 0,    C_R,     0, 1, 1);
    for (int i = 0; i < 3; i++)
      applyStimulus(I_MFLO, 1, 0, 0, 0, 1,    C_NOP,   0, 0, 1);
    applyStimulus(I_MFLO,  1, 0, 0,  0, 1,    C_NOP,   0, 0, 0);
    applyStimulus(I_MFLO,  1, 0, 0,  0, 0,    C_R,     0, 0, 0);

    applyStimulus(I_DIVU,  1, 0, 0,  0, 0,    C_R,     0, 1, 1);
    applyStimulus(I_MULTU, 1, 0, 0,  0, 1,    C_NOP,   0, 0, 1);
    applyStimulus(I_MULTU, 1, 0, 0,  1, 0,    C_NOP,   0, 0, 1);
    applyStimulus(I_MULTU, 1, 0, 0,  0, 1,    C_NOP,   0, 0, 1);
    applyStimulus(I_MULTU, 1, 0, 0,  0, 1,    C_NOP,   0, 0, 0);
    applyStimulus(I_MULTU, 1, 0, 0,  0, 0,    C_R,     0, 1, 1);

    applyStimulus(I_MULTU, 1, 1, 5,  0, 1,    C_NOP,   0, 0, 1);
    applyStimulus(I_MULTU, 1, 0, 0,  0, 1,    C_NOP,   0, 0, 1);
    applyStimulus(I_MULTU, 1, 1, 6,  0, 1,    C_NOP,   0, 0, 1);
    applyStimulus(I_MULTU, 1, 1, 6,  0, 1,    C_NOP,   0, 0, 0);
    applyStimulus(I_MULTU, 1, 1, 6,  0, 1,    C_NOP,   0, 0, 0);
    applyStimulus(I_MULTU, 1, 0, 0,  0, 0,    C_R,     0, 1, 1);
    applyStimulus(I_ADDIU, 1, 0, 0,  0, 0,    C_ADDIU, 0, 0, 1);

    // Counter now holds 2; reset lands mid-cycle to show it is asynchronous.
    @(posedge clk);
    #3;
    instrIn     = '0;
    idexMemread = 1'b0;
    idexRt      = '0;
    rst         = 1'b0;
    #1;
    checkAllZero("async_reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 6; i++)
      applyStimulus(32'h0, 1, 0, 0, 0, 0, C_NOP, 0, 0, 0);
    applyStimulus(I_JAL,   1, 0, 0,  0, 0,    C_JAL,   0, 0, 0);

    @(posedge clk);
    #3;
    checkOutput("queue_drained", 0, expQ.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_ctrl_seq.md
MIPS_CTRL_SEQ -- requirements
Module: mips_ctrl_seq

Interface
REQ-001 Parameter MUL_LAT, default 32, multiplier latency in cycles (legal range 2..64).
REQ-002 Parameter HAZ_EN, default 1, enables load-use stall detection (0 = detection disabled, stall only from multiplier).
REQ-003 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 instr_in  in  32  IF/ID instruction word.
REQ-007 valid_in  in  1  instr_in holds a real instruction.
REQ-008 idex_memread, idex_rt  in  1, 5  ID/EX load flag and destination register.
REQ-009 branch_taken  in  1  EX-stage redirect (BEQ taken, J, JAL).
REQ-010 RegDst, MemtoReg, ALUOp  out  2 each  registered ID/EX control.
REQ-011 ALUSrc, RegWrite, MemRead, MemWrite, Branch, Jump  out  1 each  registered ID/EX control.
REQ-012 Mulrst  out  1  one-cycle multiplier start/clear pulse.
REQ-013 stall, pc_write, ifid_write, mul_busy, illegal  out  1 each  hazard and status outputs.

Function
REQ-014 Decode SHALL be combinational from instr_in[31:26] and [5:0]; the result SHALL be registered into the outputs on the next clk edge (latency 1).
REQ-015 Decode table: R (0) RegDst=01 RegWrite=1 ALUOp=10; LW (35) ALUSrc=1 MemtoReg=01 RegWrite=1 MemRead=1; SW (43) ALUSrc=1 MemWrite=1; BEQ (4) Branch=1 ALUOp=01; J (2) Branch=1 Jump=1; JAL (3) RegDst=10 MemtoReg=10 RegWrite=1 Branch=1 Jump=1; ADDIU (9) ALUSrc=1 RegWrite=1; all unlisted fields 0.
REQ-016 instr_in == 0, valid_in == 0, or a bubble SHALL register the all-zero control word; no output SHALL ever be X.
REQ-017 An unknown opcode SHALL register the all-zero word and pulse illegal for 1 cycle.
REQ-018 Load-use: if HAZ_EN, idex_memread=1, idex_rt!=0 and idex_rt equals rs or rt of instr_in, then stall=1 for 1 cycle and a bubble is registered.
REQ-019 pc_write = ifid_write = ~stall, combinational.
REQ-020 FSM states IDLE and MBUSY; reset state IDLE.
REQ-021 In IDLE, R-type funct 0x19 (MULTU) or 0x1B (DIVU) SHALL pulse Mulrst for 1 cycle, load the counter with MUL_LAT-1 and enter MBUSY.
REQ-022 In MBUSY the counter SHALL decrement each cycle; the transition to IDLE SHALL occur on the edge where the counter equals 0; mul_busy=1 throughout MBUSY.
REQ-023 In MBUSY, MFHI (0x10), MFLO (0x12), MULTU or DIVU in ID SHALL assert stall; a stalled MULTU SHALL start in the cycle after the return to IDLE.
REQ-024 branch_taken=1 SHALL register a bubble (flush) and SHALL override stall; the multiplier FSM SHALL continue counting.
REQ-025 Simultaneous load-use and multiplier stall SHALL produce a single stall; stall SHALL deassert only when both causes clear.
REQ-026 Counter width SHALL be $clog2(MUL_LAT); the counter SHALL never wrap below 0.

Reset
REQ-027 rst low SHALL immediately force every registered output to 0, the FSM to IDLE, the counter to 0, and Mulrst, illegal and mul_busy to 0.
REQ-028 Reset during MBUSY SHALL abandon the operation; no Mulrst SHALL be emitted on release.

Structure
REQ-029 Opcode and funct constants, the RegDst, MemtoReg and ALUOp encodings, and the control-word width SHALL live in the shared package mips_pkg.
REQ-030 The multiplier FSM and counter SHALL be the sub-module mul_seq_tracker (ports: clk, rst, start, busy, done).

Verification
REQ-031 LW 0x8C020004 then ADDU rs=2 -> stall=1 for exactly 1 cycle, bubble registered, ADDU control word (RegDst=01, ALUOp=10) on the next cycle.
REQ-032 MULTU, MUL_LAT=4, then MFLO -> Mulrst for 1 cycle, mul_busy for 4 cycles, MFLO stalled for 4 cycles then issued.
REQ-033 BEQ with branch_taken=1 during a load-use stall -> outputs all-zero next cycle, stall=0.
REQ-034 opcode 0x3F -> all-zero control word, illegal for 1 cycle, no X on any output.
REQ-035 rst asserted mid-MBUSY (counter=2) -> outputs 0 asynchronously, mul_busy=0, no Mulrst after release.
REQ-036 JAL 0x0C000010 -> RegDst=10, MemtoReg=10, RegWrite=1, Jump=1, Branch=1 one cycle after presentation.
